mem_stage_sram: RTL and testbench

//  MEM stage of the 5-stage ARM pipeline; sits between the EXE/MEM pipeline register and the MEM/WB register.

---
 rtl/mem_stage_sram.sv | 149 ++++++++++++++
 tb/tb_mem_stage_sram.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram.sv
`default_nettype none
// ============================================================================
// Module     : mem_stage_sram
// Description: MEM stage of a 5-stage ARM pipeline. A 32-bit load or store
//              becomes two sequential 16-bit accesses on an external SRAM,
//              low halfword first. The stage holds freeze high to stall the
//              pipeline until the access completes. WB control, Dest and
//              ALU_result pass straight through to the MEM/WB register.
// Ports      : clk, rst (sync, active-low)
//              WB_en, MEM_R_EN, MEM_W_EN, ALU_result, ST_val, Dest  - EXE/MEM
//              WB_en_out, MEM_R_EN_out, ALU_result_out, Dest_out    - MEM/WB
//              mem_data (registered read word), freeze (pipeline stall)
//              SRAM_ADDR, SRAM_DQ_in, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
// Revision   : 1.0 - initial release
// ============================================================================
module mem_stage_sram #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          SRAM_AW     = 18,
   parameter int          WAIT_CYCLES = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               WB_en,
   input  logic               MEM_R_EN,
   input  logic               MEM_W_EN,
   input  logic [31:0]        ALU_result,
   input  logic [31:0]        ST_val,
   input  logic [3:0]         Dest,
   output logic               WB_en_out,
   output logic               MEM_R_EN_out,
   output logic [31:0]        ALU_result_out,
   output logic [3:0]         Dest_out,
   output logic [31:0]        mem_data,
   output logic               freeze,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   input  logic [15:0]        SRAM_DQ_in,
   output logic [15:0]        SRAM_DQ_out,
   output logic               SRAM_DQ_oe,
   output logic               SRAM_WE_N
);

   localparam int                CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      mem_data_q, mem_data_d;

   logic             req;
   logic             is_read;
   logic             is_write;
   logic             cnt_last;
   logic             in_access;
   logic [31:0]      offset;
   logic [SRAM_AW-2:0] idx;
   logic             unused_offset_bits;

   // A read wins when both enables are set.
   assign req      = MEM_R_EN | MEM_W_EN;
   assign is_read  = MEM_R_EN;
   assign is_write = MEM_W_EN & ~MEM_R_EN;
   assign cnt_last = (cnt_q == CNT_LAST);
   assign in_access = (state_q == ST_LO) || (state_q == ST_HI);

   // Word index into SRAM: byte offset with 32-bit wrap, word-aligned, then
   // truncated to the halfword address space minus the halfword-select bit.
   assign offset = ALU_result - BASE_ADDR;
   assign idx    = offset[SRAM_AW:2];
   assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

   // Pipeline pass-through.
   assign WB_en_out      = WB_en;
   assign MEM_R_EN_out   = MEM_R_EN;
   assign ALU_result_out = ALU_result;
   assign Dest_out       = Dest;
   assign mem_data       = mem_data_q;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         mem_data_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_data_q <= mem_data_d;
      end
   end

   // ---------------------------------------------------------- next-state comb
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mem_data_d = mem_data_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (req) state_d = ST_LO;
         end
         ST_LO: begin
            if (cnt_last) begin
               state_d = ST_HI;
               cnt_d   = '0;
               if (is_read) mem_data_d[15:0] = SRAM_DQ_in;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HI: begin
            if (cnt_last) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               if (is_read) mem_data_d[31:16] = SRAM_DQ_in;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            // DONE: pipeline advances on this edge, next op starts from IDLE.
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // -------------------------------------------------------------- output comb
   always_comb begin
      freeze      = req & (state_q != ST_DONE);
      SRAM_ADDR   = {idx, 1'b0};
      SRAM_DQ_oe  = 1'b0;
      SRAM_DQ_out = 16'h0;
      SRAM_WE_N   = 1'b1;
      if ((state_q == ST_HI) || (state_q == ST_DONE)) SRAM_ADDR = {idx, 1'b1};
      if (in_access && is_write) begin
         SRAM_DQ_oe  = 1'b1;
         SRAM_DQ_out = (state_q == ST_HI) ? ST_val[31:16] : ST_val[15:0];
         // Last cycle of each halfword keeps address/data stable with WE_N high.
         SRAM_WE_N   = cnt_last;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram.sv
`default_nettype none
// ============================================================================
// Module     : tb_mem_stage_sram
// Description: Self-checking bench for mem_stage_sram with a behavioural
//              SRAM model and an expected-result queue.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mem_stage_sram;

   logic        clk = 1'b0;
   logic        rst;
   logic        WB_en, MEM_R_EN, MEM_W_EN;
   logic [31:0] ALU_result, ST_val;
   logic [3:0]  Dest;
   logic        WB_en_out, MEM_R_EN_out;
   logic [31:0] ALU_result_out, mem_data;
   logic [3:0]  Dest_out;
   logic        freeze;
   logic [17:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ_in, SRAM_DQ_out;
   logic        SRAM_DQ_oe, SRAM_WE_N;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_w;

   int          obs_fcyc, obs_welo, obs_oe;
   logic [17:0] obs_a_first, obs_a_done;

   logic [15:0] sram [0:1023];
   logic        preload;

   always #5 clk = ~clk;

   mem_stage_sram #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(5)) dut (
      .clk(clk), .rst(rst), .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .ALU_result(ALU_result), .ST_val(ST_val), .Dest(Dest),
      .WB_en_out(WB_en_out), .MEM_R_EN_out(MEM_R_EN_out),
      .ALU_result_out(ALU_result_out), .Dest_out(Dest_out),
      .mem_data(mem_data), .freeze(freeze), .SRAM_ADDR(SRAM_ADDR),
      .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_out(SRAM_DQ_out),
      .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N)
   );

   // Behavioural SRAM: asynchronous read, write on clock edge while WE_N low.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) sram[i] <= 16'h0;
         sram[0] <= 16'h5678;
         sram[1] <= 16'h1234;
      end else if (!SRAM_WE_N && SRAM_DQ_oe) begin
         sram[SRAM_ADDR[9:0]] <= SRAM_DQ_out;
      end
   end
   assign SRAM_DQ_in = sram[SRAM_ADDR[9:0]];

   // Drive one request and follow it until freeze drops (the DONE cycle).
   task automatic run_op(input logic r, input logic w, input logic [31:0] addr,
                         input logic [31:0] st);
      @(negedge clk);
      MEM_R_EN = r; MEM_W_EN = w; ALU_result = addr; ST_val = st;
      WB_en = r; Dest = 4'h3;
      #1;
      obs_a_first = SRAM_ADDR;
      obs_fcyc = 0; obs_welo = 0; obs_oe = 0;
      while (freeze === 1'b1 && obs_fcyc < 100) begin
         obs_fcyc++;
         if (SRAM_WE_N === 1'b0) obs_welo++;
         if (SRAM_DQ_oe === 1'b1) obs_oe++;
         @(negedge clk); #1;
      end
      obs_a_done = SRAM_ADDR;
   endtask

   task automatic go_idle();
      @(negedge clk);
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; WB_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; preload = 1'b1;
      WB_en = 0; MEM_R_EN = 0; MEM_W_EN = 0; ALU_result = 0; ST_val = 0; Dest = 0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL reset_mem_data: got %h expected %h", mem_data, 32'h0); end
      checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", SRAM_WE_N); end
      checks++; if (SRAM_DQ_oe !== 1'b0) begin errors++; $display("FAIL reset_dq_oe: got %b expected 0", SRAM_DQ_oe); end
      checks++; if (SRAM_DQ_out !== 16'h0) begin errors++; $display("FAIL reset_dq_out: got %h expected 0000", SRAM_DQ_out); end
      checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %b expected 0", freeze); end
      @(negedge clk);
      preload = 1'b0; rst = 1'b1;
   endtask

   task automatic test_store();
      exp_q.push_back(32'hDEADBEEF);
      run_op(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
      checks++; if (obs_fcyc != 11) begin errors++; $display("FAIL store_freeze_cycles: got %0d expected 11", obs_fcyc); end
      checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL store_freeze_done: got %b expected 0", freeze); end
      checks++; if (obs_a_first !== 18'd4) begin errors++; $display("FAIL store_addr_lo: got %0d expected 4", obs_a_first); end
      checks++; if (obs_a_done !== 18'd5) begin errors++; $display("FAIL store_addr_hi: got %0d expected 5", obs_a_done); end
      checks++; if (obs_welo != 8) begin errors++; $display("FAIL store_we_low_cycles: got %0d expected 8", obs_welo); end
      checks++; if (obs_oe != 10) begin errors++; $display("FAIL store_oe_cycles: got %0d expected 10", obs_oe); end
      exp_w = exp_q.pop_front();
      checks++; if ({sram[5], sram[4]} !== exp_w) begin errors++; $display("FAIL store_sram_data: got %h expected %h", {sram[5], sram[4]}, exp_w); end
   endtask

   task automatic test_load();
      exp_q.push_back(32'hDEADBEEF);
      run_op(1'b1, 1'b0, 32'd1032, 32'h0);
      checks++; if (obs_fcyc != 11) begin errors++; $display("FAIL load_freeze_cycles: got %0d expected 11", obs_fcyc); end
      checks++; if (obs_welo != 0) begin errors++; $display("FAIL load_we_low_cycles: got %0d expected 0", obs_welo); end
      checks++; if (obs_oe != 0) begin errors++; $display("FAIL load_oe_cycles: got %0d expected 0", obs_oe); end
      exp_w = exp_q.pop_front();
      checks++; if (mem_data !== exp_w) begin errors++; $display("FAIL load_mem_data: got %h expected %h", mem_data, exp_w); end
   endtask

   task automatic test_alu();
      logic [31:0] pat [3];
      pat[0] = 32'h0000_0400; pat[1] = 32'hFFFF_FFFF; pat[2] = 32'h1357_9BDF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         MEM_R_EN = 0; MEM_W_EN = 0; WB_en = i[0]; Dest = 4'(i + 9);
         ALU_result = pat[i]; ST_val = ~pat[i];
         #1;
         checks++; if (freeze !== 1'b0 || SRAM_WE_N !== 1'b1 || SRAM_DQ_oe !== 1'b0) begin
            errors++; $display("FAIL alu_no_sram: got freeze=%b we_n=%b oe=%b expected 0 1 0", freeze, SRAM_WE_N, SRAM_DQ_oe); end
         checks++; if ({WB_en_out, MEM_R_EN_out, Dest_out, ALU_result_out} !== {i[0], 1'b0, 4'(i + 9), pat[i]}) begin
            errors++; $display("FAIL alu_passthrough: got %h expected %h",
               {WB_en_out, MEM_R_EN_out, Dest_out, ALU_result_out}, {i[0], 1'b0, 4'(i + 9), pat[i]}); end
      end
   endtask

   task automatic test_both_enables();
      // Low address bits ignored: 1026 maps to halfwords 0/1.
      exp_q.push_back(32'h12345678);
      run_op(1'b1, 1'b1, 32'd1026, 32'hA5A5_5A5A);
      checks++; if (obs_fcyc != 11) begin errors++; $display("FAIL both_freeze_cycles: got %0d expected 11", obs_fcyc); end
      checks++; if (obs_welo != 0 || obs_oe != 0) begin errors++; $display("FAIL both_no_write: got we_low=%0d oe=%0d expected 0 0", obs_welo, obs_oe); end
      exp_w = exp_q.pop_front();
      checks++; if (mem_data !== exp_w) begin errors++; $display("FAIL both_mem_data: got %h expected %h", mem_data, exp_w); end
      checks++; if ({sram[1], sram[0]} !== 32'h12345678) begin errors++; $display("FAIL both_sram_unchanged: got %h expected 12345678", {sram[1], sram[0]}); end
   endtask

   task automatic test_reset_mid_read();
      int fcyc;
      @(negedge clk);
      MEM_R_EN = 1; MEM_W_EN = 0; ALU_result = 32'd1032; WB_en = 1;
      #1;
      repeat (7) begin @(negedge clk); #1; end
      checks++; if (freeze !== 1'b1 || SRAM_ADDR !== 18'd5) begin errors++; $display("FAIL rstmid_in_hi: got freeze=%b addr=%0d expected 1 5", freeze, SRAM_ADDR); end
      rst = 1'b0;
      @(negedge clk); #1;
      checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL rstmid_mem_data: got %h expected 0", mem_data); end
      checks++; if (SRAM_WE_N !== 1'b1 || freeze !== 1'b1 || SRAM_ADDR !== 18'd4) begin
         errors++; $display("FAIL rstmid_idle: got we_n=%b freeze=%b addr=%0d expected 1 1 4", SRAM_WE_N, freeze, SRAM_ADDR); end
      rst = 1'b1;
      exp_q.push_back(32'hDEADBEEF);
      fcyc = 0;
      while (freeze === 1'b1 && fcyc < 100) begin fcyc++; @(negedge clk); #1; end
      checks++; if (fcyc != 11) begin errors++; $display("FAIL rstmid_restart_cycles: got %0d expected 11", fcyc); end
      exp_w = exp_q.pop_front();
      checks++; if (mem_data !== exp_w) begin errors++; $display("FAIL rstmid_mem_data_after: got %h expected %h", mem_data, exp_w); end
   endtask

   task automatic test_back_to_back();
      exp_q.push_back(32'h12345678);
      run_op(1'b1, 1'b0, 32'd1024, 32'h0);
      checks++; if (obs_a_first !== 18'd0 || obs_a_done !== 18'd1) begin errors++; $display("FAIL b2b_load_addr: got %0d/%0d expected 0/1", obs_a_first, obs_a_done); end
      checks++; if (obs_fcyc != 11) begin errors++; $display("FAIL b2b_load_cycles: got %0d expected 11", obs_fcyc); end
      exp_w = exp_q.pop_front();
      checks++; if (mem_data !== exp_w) begin errors++; $display("FAIL b2b_load_data: got %h expected %h", mem_data, exp_w); end
      exp_q.push_back(32'hCAFEF00D);
      run_op(1'b0, 1'b1, 32'd2044, 32'hCAFEF00D);
      checks++; if (obs_a_first !== 18'd510 || obs_a_done !== 18'd511) begin errors++; $display("FAIL b2b_store_addr: got %0d/%0d expected 510/511", obs_a_first, obs_a_done); end
      checks++; if (obs_fcyc != 11) begin errors++; $display("FAIL b2b_store_cycles: got %0d expected 11", obs_fcyc); end
      exp_w = exp_q.pop_front();
      checks++; if ({sram[511], sram[510]} !== exp_w) begin errors++; $display("FAIL b2b_store_data: got %h expected %h", {sram[511], sram[510]}, exp_w); end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_alu();
      test_both_enables();
      test_reset_mid_read();
      test_back_to_back();
      go_idle();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
